// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between core, APB and SPI.
// Each grant runs a one-cycle command phase and, for reads, a response phase.
module mem_port_arbiter #(
    parameter int DATA_LENGTH    = 32,
    parameter int ADDRESS_LENGTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_mode,
    output logic                      core_stall,
    input  logic                      core_req,
    input  logic                      core_wr,
    input  logic [ADDRESS_LENGTH-1:0] core_addr,
    input  logic [DATA_LENGTH-1:0]    core_wdata,
    input  logic [1:0]                core_len,
    output logic                      core_gnt,
    output logic                      core_rvalid,
    input  logic                      apb_req,
    input  logic                      apb_wr,
    input  logic [ADDRESS_LENGTH-1:0] apb_addr,
    input  logic [DATA_LENGTH-1:0]    apb_wdata,
    input  logic [1:0]                apb_len,
    output logic                      apb_gnt,
    output logic                      apb_rvalid,
    input  logic                      spi_req,
    input  logic                      spi_wr,
    input  logic [ADDRESS_LENGTH-1:0] spi_addr,
    input  logic [DATA_LENGTH-1:0]    spi_wdata,
    input  logic [1:0]                spi_len,
    output logic                      spi_gnt,
    output logic                      spi_rvalid,
    output logic [DATA_LENGTH-1:0]    rdata,
    output logic                      busy,
    output logic                      mem_en,
    output logic                      mem_wr_en,
    output logic                      mem_rd_en,
    output logic [ADDRESS_LENGTH-1:0] mem_address,
    output logic [DATA_LENGTH-1:0]    mem_data_in,
    output logic [1:0]                mem_data_length,
    input  logic [DATA_LENGTH-1:0]    mem_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {R_CORE, R_APB, R_SPI} req_id_t;

    state_t  state;
    state_t  state_nxt;
    req_id_t last_grant;
    req_id_t winner;

    logic [2:0] eff_req;
    logic       any_req;
    logic [2:0] win_oh;
    logic [2:0] owner_oh;
    logic [2:0] gnt_q;
    logic [2:0] rvalid_q;

    logic                      sel_wr;
    logic [ADDRESS_LENGTH-1:0] sel_addr;
    logic [DATA_LENGTH-1:0]    sel_wdata;
    logic [1:0]                sel_len;

    assign eff_req    = {spi_req, apb_req, core_req & ~load_mode};
    assign any_req    = |eff_req;
    assign core_stall = load_mode & core_req;
    assign busy       = (state != IDLE);

    // Search begins just after the last winner: core -> apb -> spi -> core.
    always_comb begin
        winner = R_CORE;
        unique case (last_grant)
            R_CORE: begin
                if (eff_req[1])      winner = R_APB;
                else if (eff_req[2]) winner = R_SPI;
                else                 winner = R_CORE;
            end
            R_APB: begin
                if (eff_req[2])      winner = R_SPI;
                else if (eff_req[0]) winner = R_CORE;
                else                 winner = R_APB;
            end
            default: begin
                if (eff_req[0])      winner = R_CORE;
                else if (eff_req[1]) winner = R_APB;
                else                 winner = R_SPI;
            end
        endcase
    end

    assign win_oh = {winner == R_SPI, winner == R_APB, winner == R_CORE};

    always_comb begin
        sel_wr    = core_wr;
        sel_addr  = core_addr;
        sel_wdata = core_wdata;
        sel_len   = core_len;
        unique case (winner)
            R_APB: begin
                sel_wr    = apb_wr;
                sel_addr  = apb_addr;
                sel_wdata = apb_wdata;
                sel_len   = apb_len;
            end
            R_SPI: begin
                sel_wr    = spi_wr;
                sel_addr  = spi_addr;
                sel_wdata = spi_wdata;
                sel_len   = spi_len;
            end
            default: begin
                sel_wr    = core_wr;
                sel_addr  = core_addr;
                sel_wdata = core_wdata;
                sel_len   = core_len;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = any_req ? ACCESS : IDLE;
            ACCESS:  state_nxt = mem_wr_en ? IDLE : RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The memory command registers double as the latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant      <= R_SPI;
            owner_oh        <= 3'b000;
            gnt_q           <= 3'b000;
            rvalid_q        <= 3'b000;
            rdata           <= '0;
            mem_en          <= 1'b0;
            mem_wr_en       <= 1'b0;
            mem_rd_en       <= 1'b0;
            mem_address     <= '0;
            mem_data_in     <= '0;
            mem_data_length <= 2'b00;
        end else begin
            gnt_q     <= 3'b000;
            rvalid_q  <= 3'b000;
            mem_en    <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        last_grant      <= winner;
                        owner_oh        <= win_oh;
                        gnt_q           <= win_oh;
                        mem_en          <= 1'b1;
                        mem_wr_en       <= sel_wr;
                        mem_rd_en       <= ~sel_wr;
                        mem_address     <= sel_addr;
                        mem_data_in     <= sel_wdata;
                        mem_data_length <= sel_len;
                    end
                end
                RESP: begin
                    rdata    <= mem_data_out;
                    rvalid_q <= owner_oh;
                end
                default: begin
                end
            endcase
        end
    end

    assign core_gnt    = gnt_q[0];
    assign apb_gnt     = gnt_q[1];
    assign spi_gnt     = gnt_q[2];
    assign core_rvalid = rvalid_q[0];
    assign apb_rvalid  = rvalid_q[1];
    assign spi_rvalid  = rvalid_q[2];

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port of the memory wrapper between three requesters: core, APB bridge, SPI bridge.
- Arbitration is round-robin. Each request is sequenced through a registered command phase and, for reads, a response phase.
- Load mode blocks the core while instructions are loaded over APB/SPI.
- Sits between the bus bridges/core and the memory wrapper in the multicycle top.

Parameters:
DATA_LENGTH, 32, data bus width
ADDRESS_LENGTH, 12, memory address width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
load_mode  input  1  1 = core requests masked (instruction load in progress)
core_stall  output  1  high while load_mode=1 and core_req=1
{r}_req  input  1  request; r = core, apb, spi; held until {r}_gnt
{r}_wr  input  1  1 = write, 0 = read
{r}_addr  input  ADDRESS_LENGTH  address
{r}_wdata  input  DATA_LENGTH  write data
{r}_len  input  2  access length code, forwarded unchanged
{r}_gnt  output  1  one-cycle pulse: command accepted
{r}_rvalid  output  1  one-cycle pulse: rdata valid for requester r
rdata  output  DATA_LENGTH  read data, shared by all requesters
busy  output  1  state != IDLE
mem_en  output  1  memory enable
mem_wr_en  output  1  memory write enable
mem_rd_en  output  1  memory read enable
mem_address  output  ADDRESS_LENGTH  memory address
mem_data_in  output  DATA_LENGTH  memory write data
mem_data_length  output  2  memory length code
mem_data_out  input  DATA_LENGTH  memory read data, valid the cycle after mem_en with mem_rd_en

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs 0, rdata 0, state IDLE.
  - Round-robin pointer set to last_grant=spi, so core has first priority.
  - Applies mid-transaction: the in-flight access is dropped and no gnt/rvalid is issued.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Effective requests: core_req&~load_mode, apb_req, spi_req.
  - If any is set, pick the winner by round-robin: search starts after last_grant in order core→apb→spi→core.
  - Register the winner's wr/addr/wdata/len, set last_grant=winner, go to ACCESS.
  - If none is set, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Drive mem_en=1, mem_wr_en=wr, mem_rd_en=~wr, and mem_address/mem_data_in/mem_data_length from the registered command.
  - {winner}_gnt=1 this cycle.
  - Write: next state IDLE. Read: next state RESP.
- RESP (exactly 1 cycle):
  - mem_en=0. Capture mem_data_out into rdata at the end of the cycle.
  - Next state IDLE, with {winner}_rvalid=1 in that following cycle.
  - rdata holds its value until the next read capture.
- Latency, with req sampled at edge N while in IDLE:
  - gnt and mem command in cycle N+1.
  - Write: complete in N+1; the next arbitration sample is at edge N+2.
  - Read: rvalid and rdata in cycle N+3. During N+3 the block is in IDLE and may arbitrate again, so back-to-back reads issue every 3 cycles.
- Memory outputs (mem_*) are registered. All are 0 outside ACCESS except mem_address, mem_data_in and mem_data_length, which hold their last values.
- Requesters must hold req and command stable until gnt.
  - A req deasserted before it is sampled in IDLE is simply not served.
  - Command changes after sampling are ignored.
- load_mode:
  - Masks the core only at the arbitration decision. A core access already granted completes normally.
  - core_stall = load_mode & core_req, combinational.
- Simultaneous requests: exactly one gnt per transaction. Any non-winning requester is served within 2 further transactions (starvation-free).
- Only one outstanding transaction at a time. At most one of the gnt/rvalid outputs is high per cycle.

Test Plan:
- Reset, then core read of addr 0x010, memory returns 0xDEADBEEF → core_gnt at N+1 with mem_rd_en=1, mem_address=0x010; core_rvalid=1, rdata=0xDEADBEEF at N+3; other gnt/rvalid stay 0.
- All three requesters request writes continuously from reset → gnt order core, apb, spi, core, …; one gnt every 2 cycles; mem_data_in matches each owner's wdata.
- load_mode=1 with core_req and apb write addr 0x004 data 0x00000013 → only apb_gnt; core_stall=1; core is granted the first arbitration after load_mode drops.
- rst=1 in the RESP cycle of an apb read → no apb_rvalid; all outputs 0 next cycle; the next simultaneous core+spi request grants core first.
- spi_req pulses 1 cycle while the block is in ACCESS serving apb, and drops before the next IDLE sample → spi is never granted; busy returns to 0.
